// File: rtl/subckt_bist_pkg.sv
// Shared constants for the subcircuit BIST sequencer: state codes, polynomial,
// default seed, INIT length and the Galois step shared by the LFSR and the MISR.
package subckt_bist_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_APPLY   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [15:0] POLY         = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int unsigned INIT_LEN     = 2;

    // One right-shift Galois step, with xin folded into bit 0 for signature compaction.
    function automatic logic [15:0] galois_step(input logic [15:0] v, input logic xin);
        return ({1'b0, v[15:1]} ^ (v[0] ? POLY : 16'h0000)) ^ {15'b0, xin};
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Galois shift register with load and step; used as the pattern LFSR
// (xin tied low) and as the MISR (xin = DUT output). Exposes the low OUT_W bits.
module bist_lfsr16
    import subckt_bist_pkg::*;
#(
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [15:0]      load_val,
    input  logic             step,
    input  logic             xin,
    output logic [OUT_W-1:0] q,
    output logic [OUT_W-1:0] nxt
);

    logic [15:0] reg_q;
    logic [15:0] reg_nxt;

    assign reg_nxt = galois_step(reg_q, xin);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            reg_q <= 16'h0000;
        else if (load)
            reg_q <= load_val;
        else if (step)
            reg_q <= reg_nxt;
    end

    assign q   = reg_q[OUT_W-1:0];
    assign nxt = reg_nxt[OUT_W-1:0];

endmodule

// File: rtl/subckt_bist_ctrl.sv
// BIST sequencer for one subcircuit: holds the DUT in reset, applies N LFSR
// patterns with a settle time each, compacts dut_out into a MISR and reports pass/fail.
module subckt_bist_ctrl
    import subckt_bist_pkg::*;
#(
    parameter int unsigned IN_W   = 7,
    parameter int unsigned SETTLE = 2,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic            I1470,
    input  logic            I1477,
    input  logic            start,
    input  logic [15:0]     n_patterns,
    input  logic [15:0]     expected_sig,
    input  logic            dut_out,
    output logic [IN_W-1:0] dut_in,
    output logic            dut_rst_n,
    output logic            busy,
    output logic            done,
    output logic [15:0]     signature,
    output logic            pass
);

    localparam logic [15:0] LOAD_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [2:0]      state;
    logic [15:0]     n_lat;
    logic [15:0]     exp_lat;
    logic [15:0]     pcnt;
    logic [15:0]     tcnt;
    logic            accept;
    logic            capture;
    logic            last;
    logic [IN_W-1:0] lfsr_q;
    logic [IN_W-1:0] lfsr_nxt;
    logic [15:0]     misr_q;
    logic [15:0]     misr_nxt;

    assign accept  = (state == S_IDLE) && start;
    assign capture = (state == S_CAPTURE);
    assign last    = (pcnt + 16'd1) == n_lat;

    bist_lfsr16 #(.OUT_W(IN_W)) u_lfsr (
        .clk      (I1470),
        .rst      (I1477),
        .load     (accept),
        .load_val (LOAD_SEED),
        .step     (capture),
        .xin      (1'b0),
        .q        (lfsr_q),
        .nxt      (lfsr_nxt)
    );

    bist_lfsr16 #(.OUT_W(16)) u_misr (
        .clk      (I1470),
        .rst      (I1477),
        .load     (accept),
        .load_val (16'h0000),
        .step     (capture),
        .xin      (dut_out),
        .q        (misr_q),
        .nxt      (misr_nxt)
    );

    always_ff @(posedge I1470) begin
        if (I1477) begin
            state     <= S_IDLE;
            n_lat     <= 16'h0000;
            exp_lat   <= 16'h0000;
            pcnt      <= 16'h0000;
            tcnt      <= 16'h0000;
            dut_in    <= '0;
            signature <= 16'h0000;
            pass      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_INIT;
                        n_lat     <= n_patterns;
                        exp_lat   <= expected_sig;
                        pcnt      <= 16'h0000;
                        tcnt      <= 16'h0000;
                        signature <= 16'h0000;
                        pass      <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (tcnt == 16'(INIT_LEN - 1)) begin
                        tcnt <= 16'h0000;
                        if (n_lat == 16'h0000) begin
                            state     <= S_DONE;
                            signature <= misr_q;
                            pass      <= (misr_q == exp_lat);
                        end else begin
                            state  <= S_APPLY;
                            dut_in <= lfsr_q;
                        end
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_APPLY: begin
                    if (tcnt == 16'(SETTLE - 1)) begin
                        tcnt  <= 16'h0000;
                        state <= S_CAPTURE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_CAPTURE: begin
                    // The signature is registered on entry to DONE so it is valid alongside the done pulse.
                    pcnt <= pcnt + 16'd1;
                    if (last) begin
                        state     <= S_DONE;
                        signature <= misr_nxt;
                        pass      <= (misr_nxt == exp_lat);
                    end else begin
                        state  <= S_APPLY;
                        dut_in <= lfsr_nxt;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dut_rst_n = (state == S_APPLY) || (state == S_CAPTURE);

endmodule

// File: tb/tb_subckt_bist_ctrl.sv
// Self-checking bench for subckt_bist_ctrl: a per-cycle expectation queue built
// from the run rules, plus directed runs with hand-computed literal checks.
module tb_subckt_bist_ctrl;

    localparam int unsigned IN_W   = 7;
    localparam int unsigned SETTLE = 2;
    localparam logic [15:0] SEED   = 16'hACE1;

    typedef struct {
        logic            busy;
        logic            done;
        logic            rst_n;
        logic [IN_W-1:0] din;
        logic [15:0]     sig;
        logic            pass;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [15:0]     n_patterns = 16'h0000;
    logic [15:0]     expected_sig = 16'h0000;
    logic            dut_out;
    logic [IN_W-1:0] dut_in;
    logic            dut_rst_n;
    logic            busy;
    logic            done;
    logic [15:0]     signature;
    logic            pass;
    logic [1:0]      mode = 2'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Stand-in subcircuit: constant 0, constant 1, or parity of its inputs.
    function automatic logic fake(input logic [1:0] md, input logic [IN_W-1:0] d);
        return (md == 2'd2) ? ^d : md[0];
    endfunction

    assign dut_out = fake(mode, dut_in);

    subckt_bist_ctrl #(.IN_W(IN_W), .SETTLE(SETTLE), .SEED(SEED)) dut (
        .I1470        (clk),
        .I1477        (rst),
        .start        (start),
        .n_patterns   (n_patterns),
        .expected_sig (expected_sig),
        .dut_out      (dut_out),
        .dut_in       (dut_in),
        .dut_rst_n    (dut_rst_n),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
        .pass         (pass)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] gstep(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference model: queue of expected outputs, one entry per cycle of a run.
    exp_t            q[$];
    logic [IN_W-1:0] h_din  = '0;
    logic [15:0]     h_sig  = 16'h0000;
    logic            h_pass = 1'b0;
    logic            prev_idle = 1'b1;
    logic            chk_en = 1'b0;
    logic            rst_s = 1'b1;
    logic            st_s = 1'b0;
    logic [15:0]     n_s = 16'h0000;
    logic [15:0]     e_s = 16'h0000;

    task automatic build_run(input logic [15:0] n, input logic [15:0] e);
        logic [15:0]     l;
        logic [15:0]     m;
        logic [IN_W-1:0] din;
        l   = (SEED == 16'h0000) ? 16'h0001 : SEED;
        m   = 16'h0000;
        din = h_din;
        for (int i = 0; i < 2; i++)
            q.push_back('{1'b1, 1'b0, 1'b0, din, 16'h0000, 1'b0});
        for (int k = 0; k < int'(n); k++) begin
            din = l[IN_W-1:0];
            for (int s = 0; s <= int'(SETTLE); s++)
                q.push_back('{1'b1, 1'b0, 1'b1, din, 16'h0000, 1'b0});
            m = gstep(m) ^ {15'b0, fake(mode, din)};
            l = gstep(l);
        end
        q.push_back('{1'b1, 1'b1, 1'b0, din, m, (m == e)});
    endtask

    initial forever begin
        @(posedge clk);
        rst_s = rst;
        st_s  = start;
        n_s   = n_patterns;
        e_s   = expected_sig;
    end

    initial forever begin
        exp_t x;
        @(negedge clk);
        if (chk_en) begin
            if (rst_s) begin
                q.delete();
                h_din  = '0;
                h_sig  = 16'h0000;
                h_pass = 1'b0;
            end else if (st_s && prev_idle) begin
                build_run(n_s, e_s);
            end
            if (q.size() > 0) begin
                x = q.pop_front();
                prev_idle = 1'b0;
                h_din = x.din;
                if (x.done) begin
                    h_sig  = x.sig;
                    h_pass = x.pass;
                end
            end else begin
                x = '{1'b0, 1'b0, 1'b0, h_din, h_sig, h_pass};
                prev_idle = 1'b1;
            end
            check("busy", 32'(busy), 32'(x.busy));
            check("done", 32'(done), 32'(x.done));
            check("dut_rst_n", 32'(dut_rst_n), 32'(x.rst_n));
            check("dut_in", 32'(dut_in), 32'(x.din));
            check("signature", 32'(signature), 32'(x.sig));
            check("pass", 32'(pass), 32'(x.pass));
        end
    end

    // Directed stimulus
    logic [IN_W-1:0] din_at[64];

    task automatic start_run(input logic [15:0] n, input logic [15:0] e);
        @(negedge clk);
        start        = 1'b1;
        n_patterns   = n;
        expected_sig = e;
        @(posedge clk);
    endtask

    task automatic wait_done(input int pulse_at, output int lat,
                             output logic [15:0] sig, output logic ps);
        lat = -1;
        sig = 16'hxxxx;
        ps  = 1'bx;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            if (i < 64) din_at[i] = dut_in;
            if (done === 1'b1) begin
                lat = i;
                sig = signature;
                ps  = pass;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int          lat;
        logic [15:0] sig;
        logic        ps;

        // Reset held 3 cycles with start asserted throughout
        rst   = 1'b1;
        start = 1'b1;
        n_patterns = 16'd5;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dut_in", 32'(dut_in), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst_busy", 32'(busy), 32'd0);

        // N=0: straight from INIT to DONE
        start_run(16'd0, 16'h0000);
        wait_done(0, lat, sig, ps);
        check("n0_latency", 32'(lat), 32'd3);
        check("n0_sig", 32'(sig), 32'h0000);
        check("n0_pass", 32'(ps), 32'd1);
        start_run(16'd0, 16'h0005);
        wait_done(0, lat, sig, ps);
        check("n0_fail_pass", 32'(ps), 32'd0);

        // N=2, dut_out tied high
        mode = 2'd1;
        start_run(16'd2, 16'hB401);
        wait_done(0, lat, sig, ps);
        check("n2_latency", 32'(lat), 32'd9);
        check("n2_sig", 32'(sig), 32'hB401);
        check("n2_pass", 32'(ps), 32'd1);
        check("n2_pat0", 32'(din_at[3]), 32'h61);
        check("n2_pat0_held", 32'(din_at[4]), 32'h61);
        check("n2_pat1", 32'(din_at[6]), 32'h70);

        // N=1, dut_out tied low
        mode = 2'd0;
        start_run(16'd1, 16'h0001);
        wait_done(0, lat, sig, ps);
        check("n1_latency", 32'(lat), 32'd6);
        check("n1_sig", 32'(sig), 32'h0000);
        check("n1_pass", 32'(ps), 32'd0);

        // Parity DUT: clean run, then a run with a stray start during APPLY
        mode = 2'd2;
        start_run(16'd4, 16'h0000);
        wait_done(0, lat, sig, ps);
        check("n4_latency", 32'(lat), 32'd15);
        start_run(16'd4, 16'h0000);
        wait_done(4, lat, sig, ps);
        check("n4_pulse_latency", 32'(lat), 32'd15);

        // Reset in the first APPLY cycle of pattern 5 of 10, then a clean rerun
        start_run(16'd10, 16'h0000);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_apply_rst_n", 32'(dut_rst_n), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rst_n", 32'(dut_rst_n), 32'd0);
        check("mid_rst_dut_in", 32'(dut_in), 32'd0);
        check("mid_rst_sig", 32'(signature), 32'd0);
        start_run(16'd10, 16'h0000);
        wait_done(0, lat, sig, ps);
        check("n10_latency", 32'(lat), 32'd33);

        repeat (3) @(negedge clk);
        check("model_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/subckt_bist_ctrl.md
# subckt_bist_ctrl

Built-in self-test sequencer for one Nt-node benchmark subcircuit: seven inputs, one output, with internal flops on an active-low DUT reset. The block holds the DUT in reset, then releases it. It drives a pseudo-random stimulus pattern from an LFSR, waits a programmable settle time, and compacts the DUT output into a MISR signature. After N patterns it reports the signature and pass/fail against an expected value. It sits between the test-harness register file and the subcircuit under test, one instance per DUT.

## Interface
- IN_W, 7, DUT input width; patterns are LFSR bits [IN_W-1:0], IN_W ≤ 16
- SETTLE, 2, cycles each pattern is held before capture, ≥ 1
- SEED, 16'hACE1, LFSR load value at start; 16'h0000 is replaced by 16'h0001
- I1470  in  1  clock; all flops on rising edge
- I1477  in  1  reset; synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- n_patterns  in  16  number of patterns; sampled with start
- expected_sig  in  16  golden signature; sampled with start
- dut_out  in  1  DUT output
- dut_in  out  IN_W  DUT stimulus
- dut_rst_n  out  1  DUT reset, active-low
- busy  out  1  high from the cycle after start is accepted through DONE
- done  out  1  one-cycle pulse in DONE
- signature  out  16  final MISR value; held until the next accepted start
- pass  out  1  signature == expected_sig; updated in DONE, held

## Operation
- Reset values: dut_in=0, dut_rst_n=0, busy=0, done=0, signature=0, pass=0, state=IDLE, LFSR=0, MISR=0, counters=0.
- States: IDLE, INIT, APPLY, CAPTURE, DONE.
- IDLE: dut_rst_n=0. On start=1, move to INIT and latch n_patterns and expected_sig. On the same edge, load LFSR=SEED, clear MISR, clear pattern count, and clear signature and pass.
- INIT (2 cycles): dut_rst_n=0. Exit to DONE if latched N==0, else to APPLY. dut_rst_n=1 from the first APPLY cycle.
- APPLY (SETTLE cycles): dut_in=LFSR[IN_W-1:0], held stable.
- CAPTURE (1 cycle): dut_in unchanged. On exit:
  - MISR ← ((M>>1) ^ (M[0]?POLY:0)) ^ {15'b0, dut_out}
  - LFSR ← ((L>>1) ^ (L[0]?POLY:0))
  - count ← count+1
  - Next state is DONE if count+1==N, else APPLY.
- Polynomial: POLY=16'hB400, Galois right-shift, shared by the LFSR and the MISR.
- DONE (1 cycle): done=1, busy=1, signature←MISR, pass←(MISR==expected_sig), dut_rst_n=0. Return to IDLE.
- start while not IDLE: ignored, with no queuing.
- I1477 asserted in any state: all outputs and state take their reset values on that edge. No partial signature is reported.
- Count is 16-bit; N=16'hFFFF runs to completion without wrap.

## Timing
- The run starts on the edge where start is sampled in IDLE (cycle 0). busy=1 from cycle 1. INIT occupies cycles 1–2.
- Pattern k (0-based) is applied from cycle 3+k·(SETTLE+1) and captured at cycle 3+k·(SETTLE+1)+SETTLE.
- done pulses in cycle 3+N·(SETTLE+1); for N=0, done is at cycle 3.
- Earliest new start: the cycle after DONE.
- dut_in changes only on entry to APPLY; it never changes mid-settle.

## Structure
- Package subckt_bist_pkg holds:
  - the state enum
  - POLY=16'hB400
  - the default SEED
  - the INIT length constant (2)
- Sub-module bist_lfsr16 provides the step function with an optional XOR-in bit. It is instantiated twice: pattern generator with XOR-in=0, and MISR with XOR-in=dut_out.
- The controller FSM, settle counter and pattern counter live in the top level.

## Test plan
- Reset: assert I1477 for 3 cycles -> all outputs 0, state IDLE; start during reset has no effect.
- N=0, start -> done at cycle 3, signature=16'h0000; pass=1 iff expected_sig=0; dut_rst_n never goes high.
- N=2, SETTLE=2, dut_out tied 1, expected_sig=16'hB401 -> done at cycle 9, signature=16'hB401, pass=1; dut_in=7'h61 for the first pattern, then 7'h70.
- N=1, dut_out tied 0 -> signature=16'h0000; with expected_sig=16'h0001, pass=0.
- Second start pulse during APPLY -> ignored; run length and signature identical to an unperturbed run.
- I1477 asserted mid-APPLY at pattern 5 of 10 -> next cycle all outputs reset. A following start gives the same signature as a clean run.
